// File: rtl/resolved_bus_sampler.sv
// -----------------------------------------------------------------------------
// resolved_bus_sampler
//
// Clocked replacement for a continuous-assignment multi-driver net. NDRV
// 4-state drivers are resolved bit by bit under a selectable net type. A
// resolved word is committed to bus_q only after it has been seen unchanged
// on SETTLE consecutive sampled cycles. The block also counts commits whose
// value carries 0-vs-1 driver contention.
//
// Encoding (2 bits per net bit): 00 = 0, 01 = 1, 10 = z, 11 = x.
//
// Parameters:
//   WIDTH  - bits per bus
//   NDRV   - number of drivers (>= 1)
//   MODE   - 0 wire, 1 wand, 2 wor, 3 tri0, 4 tri1 (other values: wire)
//   SETTLE - consecutive matching samples before commit (0: commit on first)
//   CNT_W  - width of the saturating counters
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   in_valid      in   drv is sampled this cycle
//   drv           in   driver d at [d*2*WIDTH +: 2*WIDTH]
//   bus_q         out  last committed resolved word (reset: all z)
//   out_valid     out  one-cycle pulse on commit
//   conflict_mask out  bits of bus_q that became x through 0/1 contention
//   conflict_cnt  out  saturating count of commits with non-zero mask
//   glitch_cnt    out  (only with RESBUS_GLITCH_CNT_EN) saturating count of
//                      candidate restarts while settling
//
// Optional feature macro: RESBUS_GLITCH_CNT_EN
//
// Handshake: in_valid has no back-pressure; every cycle with in_valid=1 is a
// sample. out_valid is a single-cycle strobe with bus_q/conflict_mask valid in
// the same cycle and held until the next commit.
// -----------------------------------------------------------------------------
module resolved_bus_sampler #(
    parameter int WIDTH  = 8,
    parameter int NDRV   = 4,
    parameter int MODE   = 0,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [NDRV*2*WIDTH-1:0]   drv,
    output logic [2*WIDTH-1:0]        bus_q,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          conflict_mask,
    output logic [CNT_W-1:0]          conflict_cnt
`ifdef RESBUS_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0]          glitch_cnt
`endif
);

    localparam logic [2*WIDTH-1:0] ALL_Z = {WIDTH{2'b10}};
    // Wide enough to hold SETTLE itself (and at least one bit when SETTLE=0).
    localparam int CW = $clog2(SETTLE + 1) + 1;
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Per-bit driver census
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] has0;
    logic [WIDTH-1:0] has1;
    logic [WIDTH-1:0] hasx;

    always_comb begin
        has0 = '0;
        has1 = '0;
        hasx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int d = 0; d < NDRV; d++) begin
                case (drv[(d*2*WIDTH) + (2*i) +: 2])
                    2'b00:   has0[i] = 1'b1;
                    2'b01:   has1[i] = 1'b1;
                    2'b11:   hasx[i] = 1'b1;
                    default: ;  // z contributes nothing
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Resolution under the selected net type
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0] r;
    logic [WIDTH-1:0]   r_conf;

    always_comb begin
        r      = ALL_Z;
        r_conf = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (MODE)
                1: begin  // wand: a 0 dominates, even over x
                    if (has0[i])      r[2*i +: 2] = 2'b00;
                    else if (hasx[i]) r[2*i +: 2] = 2'b11;
                    else if (has1[i]) r[2*i +: 2] = 2'b01;
                    else              r[2*i +: 2] = 2'b10;
                end
                2: begin  // wor: a 1 dominates, even over x
                    if (has1[i])      r[2*i +: 2] = 2'b01;
                    else if (hasx[i]) r[2*i +: 2] = 2'b11;
                    else if (has0[i]) r[2*i +: 2] = 2'b00;
                    else              r[2*i +: 2] = 2'b10;
                end
                default: begin  // wire, tri0, tri1
                    // Only a 0 meeting a 1 is contention; a driven x is not.
                    r_conf[i] = has0[i] & has1[i];
                    if (hasx[i] || (has0[i] && has1[i])) r[2*i +: 2] = 2'b11;
                    else if (has0[i])                    r[2*i +: 2] = 2'b00;
                    else if (has1[i])                    r[2*i +: 2] = 2'b01;
                    else if (MODE == 3)                  r[2*i +: 2] = 2'b00;
                    else if (MODE == 4)                  r[2*i +: 2] = 2'b01;
                    else                                 r[2*i +: 2] = 2'b10;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Settle FSM
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0]   cflag_q, cflag_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               commit;
    logic [2*WIDTH-1:0] commit_val;
    logic [WIDTH-1:0]   commit_mask;
    logic               restart;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cflag_d     = cflag_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        commit_val  = cand_q;
        commit_mask = cflag_q;
        restart     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (SETTLE == 0) begin
                        commit      = 1'b1;
                        commit_val  = r;
                        commit_mask = r_conf;
                    end else begin
                        cand_d  = r;
                        cflag_d = r_conf;
                        cnt_d   = ONE_C;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // With SETTLE=1 the captured candidate is already complete and
                // is released on the following cycle without a new sample.
                if (cnt_q >= SETTLE_C) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    if (r != cand_q) begin
                        cand_d  = r;
                        cflag_d = r_conf;
                        cnt_d   = ONE_C;
                        restart = 1'b1;
                    end else if (cnt_q + ONE_C == SETTLE_C) begin
                        cnt_d   = cnt_q + ONE_C;
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cand_q  <= ALL_Z;
            cflag_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cflag_q <= cflag_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Commit outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q         <= ALL_Z;
            out_valid     <= 1'b0;
            conflict_mask <= '0;
            conflict_cnt  <= '0;
        end else begin
            out_valid <= commit;
            if (commit) begin
                bus_q         <= commit_val;
                conflict_mask <= commit_mask;
                if ((commit_mask != '0) && (conflict_cnt != {CNT_W{1'b1}})) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RESBUS_GLITCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (restart && (glitch_cnt != {CNT_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`else
    logic unused_restart;
    assign unused_restart = restart;
`endif

endmodule
